// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs request-to-send, shifts a byte on device clocks, checks line ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES       = 5000,
   parameter int START_TIMEOUT_CYCLES = 750000,
   parameter int XFER_TIMEOUT_CYCLES  = 100000,
   parameter int IDLE_TIMEOUT_CYCLES  = 100000
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       cmd_sent,
   output logic       error_timeout,
   output logic       error_no_ack
);

   localparam int M1 = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                       INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
   localparam int M2 = (XFER_TIMEOUT_CYCLES > IDLE_TIMEOUT_CYCLES) ?
                       XFER_TIMEOUT_CYCLES : IDLE_TIMEOUT_CYCLES;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int CW = $clog2(MAXC + 1);

   localparam logic [CW-1:0] INH_L = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] STA_L = CW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] XFR_L = CW'(XFER_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] IDL_L = CW'(IDLE_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_WAIT_START,
      S_XFER,
      S_WAIT_IDLE,
      S_ABORT
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, lim;
   logic [3:0]    n, n_nxt;
   logic [7:0]    sh, sh_nxt;
   logic          par, par_nxt;
   logic          nack, nack_nxt;
   logic          clk_s1, clk_s2, clk_d;
   logic          dat_s1, dat_s2;
   logic          fe, tmo;

   assign fe  = clk_d & ~clk_s2;
   assign tmo = (cnt >= lim);

   always_ff @(posedge CLOCK_50) begin
      if (!Reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         n      <= '0;
         sh     <= '0;
         par    <= 1'b0;
         nack   <= 1'b0;
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_d  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         n      <= n_nxt;
         sh     <= sh_nxt;
         par    <= par_nxt;
         nack   <= nack_nxt;
         clk_s1 <= ps2_clk_in;
         clk_s2 <= clk_s1;
         clk_d  <= clk_s2;
         dat_s1 <= ps2_dat_in;
         dat_s2 <= dat_s1;
      end
   end

   always_comb begin
      state_nxt     = state;
      n_nxt         = n;
      sh_nxt        = sh;
      par_nxt       = par;
      nack_nxt      = nack;
      lim           = '0;
      cmd_ready     = 1'b0;
      busy          = 1'b1;
      ps2_clk_oe    = 1'b0;
      ps2_dat_oe    = 1'b0;
      cmd_sent      = 1'b0;
      error_timeout = 1'b0;
      error_no_ack  = 1'b0;
      unique case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            nack_nxt  = 1'b0;
            if (cmd_valid) begin
               sh_nxt    = cmd_data;
               par_nxt   = ~^cmd_data;
               n_nxt     = '0;
               state_nxt = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            lim        = INH_L;
            if (tmo) state_nxt = S_RTS;
         end
         S_RTS: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = 1'b1;
            state_nxt  = S_WAIT_START;
         end
         S_WAIT_START: begin
            ps2_dat_oe = 1'b1;
            lim        = STA_L;
            if (fe) begin
               n_nxt     = 4'd1;
               state_nxt = S_XFER;
            end else if (tmo) begin
               state_nxt = S_ABORT;
            end
         end
         S_XFER: begin
            lim = XFR_L;
            // n counts device edges seen; bit on the line follows edge n
            if (n <= 4'd8)       ps2_dat_oe = ~sh[0];
            else if (n == 4'd9)  ps2_dat_oe = ~par;
            if (fe) begin
               if (n == 4'd10) begin
                  if (dat_s2) begin
                     nack_nxt  = 1'b1;
                     state_nxt = S_ABORT;
                  end else begin
                     state_nxt = S_WAIT_IDLE;
                  end
               end else begin
                  n_nxt = n + 4'd1;
                  if (n <= 4'd7) sh_nxt = {1'b0, sh[7:1]};
               end
            end else if (tmo) begin
               state_nxt = S_ABORT;
            end
         end
         S_WAIT_IDLE: begin
            lim = IDL_L;
            if (clk_s2 && dat_s2) begin
               cmd_sent  = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo) begin
               state_nxt = S_ABORT;
            end
         end
         S_ABORT: begin
            error_no_ack  = nack;
            error_timeout = ~nack;
            state_nxt     = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state_nxt != state || state == S_IDLE) cnt_nxt = '0;
      else if (tmo)                             cnt_nxt = cnt;
      else                                      cnt_nxt = cnt + CW'(1);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready, busy, cmd_sent, error_timeout, error_no_ack;
   logic       clk_oe, dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       clk_line, dat_line;

   int checks = 0;
   int errors = 0;
   int n_sent = 0, n_tmo = 0, n_nack = 0;
   int inh_run = 0, last_inh = 0, rts_run = 0, last_rts = 0;

   always #5 clk = ~clk;

   assign clk_line = dev_clk & ~clk_oe;
   assign dat_line = dev_dat & ~dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(20),
      .START_TIMEOUT_CYCLES(2000),
      .XFER_TIMEOUT_CYCLES(2000),
      .IDLE_TIMEOUT_CYCLES(2000)
   ) dut (
      .CLOCK_50(clk),
      .Reset(rst_n),
      .cmd_data(cmd_data),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .ps2_clk_in(clk_line),
      .ps2_dat_in(dat_line),
      .ps2_clk_oe(clk_oe),
      .ps2_dat_oe(dat_oe),
      .busy(busy),
      .cmd_sent(cmd_sent),
      .error_timeout(error_timeout),
      .error_no_ack(error_no_ack)
   );

   always @(negedge clk) begin
      if (cmd_sent)      n_sent <= n_sent + 1;
      if (error_timeout) n_tmo  <= n_tmo + 1;
      if (error_no_ack)  n_nack <= n_nack + 1;
      if (clk_oe && !dat_oe) inh_run <= inh_run + 1;
      else begin
         if (inh_run != 0) last_inh <= inh_run;
         inh_run <= 0;
      end
      if (clk_oe && dat_oe) rts_run <= rts_run + 1;
      else begin
         if (rts_run != 0) last_rts <= rts_run;
         rts_run <= 0;
      end
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         par;
      bit         exp_sent;
      bit         exp_nack;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic accept(input logic [7:0] d, input bit hold);
      bit rdy = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            rdy = 1;
            break;
         end
      end
      chk("accept_ready", rdy, 1);
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      chk("accept_busy", busy, 1);
   endtask

   task automatic dev_run(input int nedges, input bit ack,
                          output logic [9:0] bits, output bit started);
      bits    = '0;
      started = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!clk_oe && dat_oe) begin
            started = 1;
            break;
         end
      end
      if (!started) return;
      repeat (20) @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         dev_clk = 1'b0;
         repeat (50) @(negedge clk);
         if (k == nedges) return;
         dev_clk = 1'b1;
         repeat (25) @(negedge clk);
         bits[k-1] = dat_line;
         repeat (25) @(negedge clk);
      end
      dev_dat = ack ? 1'b0 : 1'b1;
      repeat (25) @(negedge clk);
      dev_clk = 1'b0;
   endtask

   task automatic complete(input bit ack, output logic [9:0] bits,
                           output bit ps, output bit pt, output bit pn);
      bit st;
      dev_run(11, ack, bits, st);
      chk("dev_start", st, 1);
      ps = 0;
      pt = 0;
      pn = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 50) dev_clk = 1'b1;
         if (i == 60) dev_dat = 1'b1;
         if (cmd_sent || error_timeout || error_no_ack) begin
            ps = cmd_sent;
            pt = error_timeout;
            pn = error_no_ack;
            break;
         end
      end
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      chk("pulse_seen", ps | pt | pn, 1);
   endtask

   task automatic chk_bits(input string tag, input logic [9:0] b,
                           input logic [7:0] d, input bit p);
      chk({tag, "_data"}, b[7:0], d);
      chk({tag, "_par"}, b[8], p);
      chk({tag, "_stop"}, b[9], 1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [9:0] b;
      bit ps, pt, pn;
      int s0, t0, k0;
      s0 = n_sent;
      t0 = n_tmo;
      k0 = n_nack;
      accept(v.data, 0);
      complete(v.ack, b, ps, pt, pn);
      chk_bits(tag, b, v.data, v.par);
      repeat (3) @(negedge clk);
      chk({tag, "_sent"}, n_sent - s0, v.exp_sent);
      chk({tag, "_nack"}, n_nack - k0, v.exp_nack);
      chk({tag, "_tmo"}, n_tmo - t0, 0);
      chk({tag, "_inhibit"}, last_inh, 20);
      chk({tag, "_rts"}, last_rts, 1);
      chk({tag, "_ready"}, cmd_ready, 1);
      chk({tag, "_oe"}, {clk_oe, dat_oe}, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] b;
      bit ps, pt, pn, st, found;
      int s0, t0, k0, cnt;

      tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{8'hAA, 1'b0, 1'b1, 1'b0, 1'b1};

      rst_n     = 1'b0;
      cmd_data  = 8'h00;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_oe", {clk_oe, dat_oe}, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {cmd_sent, error_timeout, error_no_ack}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      s0 = n_sent;
      accept(8'h01, 0);
      complete(1'b1, b, ps, pt, pn);
      chk_bits("b2b_01", b, 8'h01, 1'b0);
      chk("b2b_01_sent", ps, 1);
      cmd_data  = 8'hFF;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", cmd_ready, 1);
      @(negedge clk);
      chk("b2b_accept", busy, 1);
      cmd_valid = 1'b0;
      complete(1'b1, b, ps, pt, pn);
      chk_bits("b2b_ff", b, 8'hFF, 1'b1);
      repeat (3) @(negedge clk);
      chk("b2b_sent", n_sent - s0, 2);

      s0 = n_sent;
      t0 = n_tmo;
      k0 = n_nack;
      accept(8'h55, 0);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (clk_oe && dat_oe) begin
            found = 1;
            break;
         end
      end
      chk("tmo_rts", found, 1);
      cnt = 0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk);
         cnt++;
         if (error_timeout) break;
      end
      chk("tmo_latency", cnt, 2001);
      @(negedge clk);
      chk("tmo_oe", {clk_oe, dat_oe}, 0);
      repeat (3) @(negedge clk);
      chk("tmo_count", n_tmo - t0, 1);
      chk("tmo_sent", n_sent - s0, 0);
      chk("tmo_nack", n_nack - k0, 0);

      accept(8'hC3, 0);
      dev_run(5, 1'b1, b, st);
      chk("rst_mid_start", st, 1);
      s0 = n_sent;
      t0 = n_tmo;
      k0 = n_nack;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_oe", {clk_oe, dat_oe}, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      rst_n   = 1'b1;
      dev_clk = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst_mid_pulses", (n_sent - s0) + (n_tmo - t0) + (n_nack - k0), 0);
      run_vec('{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0}, "after_rst");

      s0 = n_sent;
      accept(8'h5A, 1);
      fork
         complete(1'b1, b, ps, pt, pn);
         begin
            for (int i = 0; i < 3000; i++) begin
               @(negedge clk);
               if (cmd_sent || error_timeout || error_no_ack) break;
               cmd_data = 8'($urandom);
            end
            cmd_valid = 1'b0;
         end
      join
      chk_bits("hold", b, 8'h5A, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold_sent", n_sent - s0, 1);
      chk("hold_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device command transmitter; the send side of the keyboard link.
- Takes a byte from the game control logic (e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable) and performs the full PS/2 request-to-send sequence.
- Shifts the byte out on device-generated clocks and checks the device line-ACK.
- Drives the open-collector PS2_CLK/PS2_DAT pads through active-high pull-low enables; the top level builds the tri-states.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time before request-to-send (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: max wait from clock release to first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: max time from first falling edge to ACK edge (2 ms).
- IDLE_TIMEOUT_CYCLES, 100000: max wait after ACK for both lines high.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- Reset  input  1  synchronous, active-low reset.
- cmd_data  input  8  command byte to send.
- cmd_valid  input  1  request; byte accepted when cmd_valid & cmd_ready.
- cmd_ready  output  1  high only in IDLE.
- ps2_clk_in  input  1  raw PS2_CLK pad value (asynchronous).
- ps2_dat_in  input  1  raw PS2_DAT pad value (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  output  1  1 = pull PS2_DAT low; 0 = release.
- busy  output  1  high in any state other than IDLE.
- cmd_sent  output  1  one-cycle pulse: ACK received and bus returned to idle.
- error_timeout  output  1  one-cycle pulse: any timeout expired.
- error_no_ack  output  1  one-cycle pulse: data high at the ACK edge.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-low.
- Reset outputs: Reset=0 at a rising edge forces IDLE. Outputs go to: clk_oe=0, dat_oe=0, cmd_ready=1, busy=0, all pulses 0. Counters and shift register are cleared. Both lines are therefore released one cycle after Reset=0 is sampled, including mid-transfer.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
  - A falling edge fe is synchronized clk previous=1, current=0.
  - All protocol decisions use the synchronized values only.
- Accept: on cmd_valid & cmd_ready, latch cmd_data into an 8-bit shift register.
  - Parity p = ~^cmd_data (odd parity: data ones plus p is odd).
  - Load bit counter n=0 and go to INHIBIT.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles.
- RTS: one cycle with clk_oe=1, dat_oe=1 (data pulled low = start bit). Then go to WAIT_START.
- WAIT_START: clk_oe=0, dat_oe=1. Count up to START_TIMEOUT_CYCLES.
  - fe arrives: go to XFER with n=1 and drive D0 (dat_oe = ~bit).
  - Timeout: go to ABORT.
- XFER, on each fe, n increments and the data line changes only right after fe:
  - n=2..8: drive D1..D7, LSB first.
  - n=9: drive parity (dat_oe = ~p).
  - n=10: release data (stop bit, dat_oe=0).
  - n=11: sample the synchronized data line.
    - Sampled 0: ACK; go to WAIT_IDLE.
    - Sampled 1: go to ABORT with error_no_ack.
  - The XFER_TIMEOUT counter runs from entry to XFER; expiry goes to ABORT.
- WAIT_IDLE: both oe=0. Wait until synchronized clk=1 and dat=1.
  - Met: pulse cmd_sent and go to IDLE.
  - IDLE_TIMEOUT expiry: go to ABORT.
- ABORT: one cycle, both oe=0. Pulse the appropriate error (error_timeout or error_no_ack, never both), then go to IDLE.
- cmd_valid outside IDLE is ignored; no queuing.
- fe during INHIBIT or RTS is ignored; those edges are our own pull-down.
- Every timeout counter resets on state entry and saturates; it never wraps.
- A new command may be accepted on the cycle after a cmd_sent or error pulse.

Test Plan:
(Bench uses INHIBIT_CYCLES=20 and all timeouts = 2000; a device model generates ~100-cycle clock periods.)
1. Send 0xED, device ACKs.
   - clk_oe high exactly 20 cycles, then RTS.
   - Data bits after edges 1..8: 1,0,1,1,0,1,1,1; parity 1; stop released.
   - cmd_sent pulses once; no errors; cmd_ready returns to 1.
2. Send 0x01 then 0xFF back-to-back.
   - Parity 0 for 0x01, parity 1 for 0xFF.
   - Second byte accepted the cycle after the first cmd_sent.
3. Device never clocks.
   - error_timeout pulses 2000 cycles after RTS.
   - Both oe=0 afterwards; cmd_sent stays 0.
4. Device leaves data high at edge 11: error_no_ack pulses once; error_timeout stays 0.
5. Reset=0 asserted after edge 5.
   - Next cycle: clk_oe=dat_oe=0, busy=0, cmd_ready=1.
   - No pulses; a new send of 0xF4 then completes normally.
6. cmd_valid held high during a transfer with changing cmd_data: only the byte latched at accept is shifted out.
